// File: rtl/afifo_rd_stream.sv
// afifo_rd_stream: read-side drain engine for the FIFO read port.
// Issues fifo_rd strobes, absorbs the one-cycle read-data latency and
// presents returned words through a 2-entry skid buffer as a valid/ready
// stream. Read issue always reserves a buffer slot for the in-flight word,
// so backpressure never drops data.
module afifo_rd_stream #(
    parameter int unsigned BITWID = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              fifo_empty,
    input  logic              fifo_almost_empty,
    output logic              fifo_rd,
    input  logic [BITWID-1:0] fifo_rd_dat,
    input  logic              fifo_rd_dat_vld,
    output logic              out_vld,
    output logic [BITWID-1:0] out_dat,
    input  logic              out_rdy,
    output logic [1:0]        buf_cnt,
    output logic              err_unexp
);

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNTW  = 2;
    // occupancy sum needs one carry bit above the counter width
    localparam int unsigned OCCW  = CNTW + 1;

    logic              infl;
    logic [CNTW-1:0]   cnt;
    logic              head;
    logic              tail;
    logic [BITWID-1:0] mem [DEPTH];

    logic              pop;
    logic              push;
    logic              full;
    logic              accept;
    logic [OCCW-1:0]   occ;

    // Stream outputs come straight from buffer state
    assign out_vld = (cnt != CNTW'(0));
    assign out_dat = mem[head];
    assign buf_cnt = cnt;

    // Handshake decode and read-issue decision
    always_comb begin
        pop     = 1'b0;
        push    = 1'b0;
        full    = 1'b0;
        accept  = 1'b0;
        occ     = '0;
        fifo_rd = 1'b0;

        pop    = out_vld & out_rdy;
        push   = fifo_rd_dat_vld;
        full   = (cnt == CNTW'(DEPTH));
        // a full buffer can still take a word when the head leaves this cycle
        accept = push & (~full | pop);
        // words held plus word in flight, minus the one leaving now
        occ    = OCCW'(cnt) + OCCW'(infl) - OCCW'(pop);
        // almost-empty throttle: no back-to-back reads so a late empty flag is safe
        fifo_rd = ~rst & en & ~fifo_empty
                & ~(fifo_almost_empty & infl)
                & (occ < OCCW'(DEPTH));
    end

    // In-flight flag, occupancy counter and ring pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            infl <= 1'b0;
            cnt  <= '0;
            head <= 1'b0;
            tail <= 1'b0;
        end else begin
            infl <= fifo_rd;
            if (accept) begin
                tail <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
            if (accept && !pop) begin
                cnt <= cnt + CNTW'(1);
            end else if (!accept && pop) begin
                cnt <= cnt - CNTW'(1);
            end
        end
    end

    // Skid-buffer storage; cleared on reset so out_dat reads zero when idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (accept) begin
            mem[tail] <= fifo_rd_dat;
        end
    end

    // Sticky error: unsolicited read data, or data arriving with no room
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_unexp <= 1'b0;
        end else if (push && (!infl || !accept)) begin
            err_unexp <= 1'b1;
        end
    end

endmodule

// File: tb/tb_afifo_rd_stream.sv
// tb_afifo_rd_stream: directed + random bench for afifo_rd_stream with a
// behavioural FIFO read port and an in-order scoreboard.
`timescale 1ns/1ps
module tb_afifo_rd_stream;

    localparam int unsigned BITWID = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              fifo_empty = 1'b1;
    logic              fifo_almost_empty = 1'b1;
    logic              fifo_rd;
    logic [BITWID-1:0] fifo_rd_dat = '0;
    logic              fifo_rd_dat_vld = 1'b0;
    logic              out_vld;
    logic [BITWID-1:0] out_dat;
    logic              out_rdy;
    logic [1:0]        buf_cnt;
    logic              err_unexp;

    int errors = 0;
    int checks = 0;

    logic [BITWID-1:0] fq[$];
    logic [BITWID-1:0] sb[$];
    int                pop_cyc[$];
    int                cyc = 0;
    int                rd_cnt = 0;
    int                empty_reads = 0;
    int                prev_sz = 0;
    int                sz = 0;
    bit                lag_mode = 1'b0;
    bit                inj_vld = 1'b0;
    bit                inv_en = 1'b1;
    logic [BITWID-1:0] inj_dat = '0;
    logic              infl_m = 1'b0;
    int                first_rd = -1;
    int                first_vld = -1;
    logic [BITWID-1:0] exp_w;
    logic [BITWID-1:0] w;
    int                rd0;
    int                produced;
    int                n;

    afifo_rd_stream #(.BITWID(BITWID)) dut (
        .clk               (clk),
        .rst               (rst),
        .en                (en),
        .fifo_empty        (fifo_empty),
        .fifo_almost_empty (fifo_almost_empty),
        .fifo_rd           (fifo_rd),
        .fifo_rd_dat       (fifo_rd_dat),
        .fifo_rd_dat_vld   (fifo_rd_dat_vld),
        .out_vld           (out_vld),
        .out_dat           (out_dat),
        .out_rdy           (out_rdy),
        .buf_cnt           (buf_cnt),
        .err_unexp         (err_unexp)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int cnt_words, input logic [BITWID-1:0] base, input bit to_sb);
        for (int i = 0; i < cnt_words; i++) begin
            fq.push_back(BITWID'(base + BITWID'(i)));
            if (to_sb) sb.push_back(BITWID'(base + BITWID'(i)));
        end
    endtask

    task automatic drain(input string tag, input int maxc);
        int k = 0;
        while ((sb.size() != 0 || out_vld) && k < maxc) begin
            nxt();
            k++;
        end
        chk(tag, 32'(sb.size()), 32'd0);
    endtask

    // Behavioural FIFO read port: one-cycle data latency, registered flags
    // (optionally one cycle late), plus an unsolicited-data injector.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_rd_dat_vld <= 1'b0;
        end else begin
            if (fifo_rd) begin
                rd_cnt++;
                if (fq.size() == 0) begin
                    empty_reads++;
                    fifo_rd_dat_vld <= 1'b0;
                end else begin
                    fifo_rd_dat     <= fq.pop_front();
                    fifo_rd_dat_vld <= 1'b1;
                end
            end else begin
                fifo_rd_dat     <= inj_dat;
                fifo_rd_dat_vld <= inj_vld;
            end
        end
        sz = fq.size();
        if (lag_mode) begin
            fifo_empty        <= (prev_sz == 0);
            fifo_almost_empty <= (prev_sz <= 3);
        end else begin
            fifo_empty        <= (sz == 0);
            fifo_almost_empty <= (sz <= 2);
        end
        prev_sz = sz;
    end

    // Reference copy of the in-flight flag as seen from the port
    always @(posedge clk or posedge rst) begin
        if (rst) infl_m <= 1'b0;
        else     infl_m <= fifo_rd;
    end

    // Output monitor: scoreboard pop, latency markers, occupancy bound
    always @(negedge clk) begin
        if (!rst) begin
            if (fifo_rd && first_rd < 0) first_rd = cyc;
            if (out_vld && first_vld < 0) first_vld = cyc;
            if (out_vld && out_rdy) begin
                pop_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    chk("extra_word", 32'(out_vld), 32'd0);
                end else begin
                    exp_w = sb.pop_front();
                    chk("out_dat", 32'(out_dat), 32'(exp_w));
                end
            end
            if (inv_en) chk("cnt_infl_le2", 32'((32'(buf_cnt) + 32'(infl_m)) <= 32'd2), 32'd1);
        end
    end

    initial begin
        #(900_000);
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        en = 1'b1;
        out_rdy = 1'b1;

        // Reset and idle with an empty FIFO
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_fifo_rd", 32'(fifo_rd), 32'd0);
        chk("rst_out_vld", 32'(out_vld), 32'd0);
        chk("rst_out_dat", 32'(out_dat), 32'd0);
        chk("rst_buf_cnt", 32'(buf_cnt), 32'd0);
        chk("rst_err", 32'(err_unexp), 32'd0);
        nxt();
        rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            chk("idle_rd", 32'(fifo_rd), 32'd0);
        end
        chk("idle_out_vld", 32'(out_vld), 32'd0);

        // Streaming 0x01..0x08 with ready held high
        nxt();
        first_rd = -1;
        first_vld = -1;
        pop_cyc.delete();
        rd0 = rd_cnt;
        load(8, 5'h01, 1'b1);
        drain("stream_drain", 60);
        chk("first_word_latency", 32'(first_vld - first_rd), 32'd2);
        chk("stream_pops", 32'(pop_cyc.size()), 32'd8);
        if (pop_cyc.size() >= 8) begin
            for (int i = 1; i < 6; i++)
                chk($sformatf("gap_full%0d", i), 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd1);
            for (int i = 6; i < 8; i++)
                chk($sformatf("gap_ae%0d", i), 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd2);
        end
        chk("stream_reads", 32'(rd_cnt - rd0), 32'd8);
        chk("stream_empty_reads", 32'(empty_reads), 32'd0);

        // Backpressure: stall 10 cycles, then release
        out_rdy = 1'b0;
        rd0 = rd_cnt;
        load(8, 5'h01, 1'b1);
        repeat (10) begin
            @(negedge clk);
            if (out_vld) chk("stall_hold", 32'(out_dat), 32'd1);
        end
        chk("stall_buf_cnt", 32'(buf_cnt), 32'd2);
        chk("stall_reads", 32'(rd_cnt - rd0), 32'd2);
        nxt();
        out_rdy = 1'b1;
        @(negedge clk);
        chk("rd_on_rdy", 32'(fifo_rd), 32'd1);
        drain("bp_drain", 60);
        chk("bp_reads", 32'(rd_cnt - rd0), 32'd8);
        chk("bp_err", 32'(err_unexp), 32'd0);

        // Random stress with a one-cycle-late empty flag
        nxt();
        lag_mode = 1'b1;
        produced = 0;
        n = 0;
        while ((produced < 10000 || sb.size() != 0) && n < 60000) begin
            nxt();
            n++;
            out_rdy = ($urandom_range(0, 3) != 0);
            en = ($urandom_range(0, 7) != 0);
            if (produced < 10000 && fq.size() < 12 && $urandom_range(0, 9) < 7) begin
                w = BITWID'($urandom);
                fq.push_back(w);
                sb.push_back(w);
                produced++;
            end
        end
        chk("stress_done", 32'(sb.size()), 32'd0);
        chk("stress_err", 32'(err_unexp), 32'd0);
        chk("stress_empty_reads", 32'(empty_reads), 32'd0);

        // Unsolicited read data with nothing in flight
        out_rdy = 1'b1;
        en = 1'b1;
        lag_mode = 1'b0;
        inv_en = 1'b0;
        repeat (3) nxt();
        chk("err_pre", 32'(err_unexp), 32'd0);
        inj_dat = 5'h15;
        inj_vld = 1'b1;
        sb.push_back(5'h15);
        nxt();
        inj_vld = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("err_set", 32'(err_unexp), 32'd1);
        repeat (5) nxt();
        chk("err_sticky", 32'(err_unexp), 32'd1);
        drain("inj_drain", 20);

        // Reset while a word is in flight and the buffer is full
        out_rdy = 1'b0;
        nxt();
        inj_vld = 1'b1;
        nxt();
        load(8, 5'h01, 1'b0);
        nxt();
        inj_vld = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_buf_cnt", 32'(buf_cnt), 32'd2);
        chk("pre_rst_infl", 32'(infl_m), 32'd1);
        rst = 1'b1;
        fq.delete();
        sb.delete();
        #1;
        chk("mid_rst_fifo_rd", 32'(fifo_rd), 32'd0);
        chk("mid_rst_out_vld", 32'(out_vld), 32'd0);
        chk("mid_rst_out_dat", 32'(out_dat), 32'd0);
        chk("mid_rst_buf_cnt", 32'(buf_cnt), 32'd0);
        chk("mid_rst_err", 32'(err_unexp), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("rst_hold_rd", 32'(fifo_rd), 32'd0);
        end
        nxt();
        rst = 1'b0;
        inv_en = 1'b1;
        @(negedge clk);
        chk("post_rst_err", 32'(err_unexp), 32'd0);

        // Short stream after reset
        nxt();
        out_rdy = 1'b1;
        load(3, 5'h0A, 1'b1);
        drain("post_rst_drain", 40);
        chk("post_rst_err_end", 32'(err_unexp), 32'd0);
        chk("final_empty_reads", 32'(empty_reads), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
